aes_req_ctrl: RTL and testbench

Initiator-side sequencer for the aes_256 engine's start/out_valid protocol.
- Accepts plaintext blocks over a valid/ready stream and holds a latched 256-bit key.
- Drives the engine's state/key/start inputs, captures out on completion and returns ciphertext over a second valid/ready stream.
- Sits between a bus-side block FIFO and the aes_top instance; one block outstanding at a time.

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_req_ctrl_if.sv | 31 +++
 rtl/aes_req_ctrl.sv | 140 ++++++++++++++
 tb/tb_aes_req_ctrl.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared widths and FSM encoding for the aes_256 request sequencer.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_KEY_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    HOLD
  } aes_req_state_e;

endpackage

// File: rtl/aes_req_ctrl_if.sv
// Block stream, result stream and engine-facing signals of aes_req_ctrl.
// master = the sequencer itself; slave = block source, engine and result consumer.
interface aes_req_ctrl_if;
  import aes_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [AES_BLK_W-1:0] in_data;

  logic [AES_BLK_W-1:0] aes_state;
  logic [AES_KEY_W-1:0] aes_key;
  logic                 aes_start;
  logic [AES_BLK_W-1:0] aes_out;
  logic                 aes_out_valid;

  logic                 res_valid;
  logic                 res_ready;
  logic [AES_BLK_W-1:0] res_data;
  logic                 res_err;

  modport master (
    input  in_valid, in_data, aes_out, aes_out_valid, res_ready,
    output in_ready, aes_state, aes_key, aes_start, res_valid, res_data, res_err
  );

  modport slave (
    output in_valid, in_data, aes_out, aes_out_valid, res_ready,
    input  in_ready, aes_state, aes_key, aes_start, res_valid, res_data, res_err
  );

endinterface

// File: rtl/aes_req_ctrl.sv
// Single-outstanding request sequencer for the aes_256 start/out_valid engine.
// Optional WAIT watchdog enabled with `define AES_TIMEOUT_EN.
module aes_req_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_load,
  input  logic [AES_KEY_W-1:0] in_key,
  aes_req_ctrl_if.master       bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     blk_cnt
);

  aes_req_state_e       state_q, state_d;
  logic [AES_KEY_W-1:0] key_q;
  logic                 key_valid_q;
  logic [AES_BLK_W-1:0] aes_state_q;
  logic [AES_KEY_W-1:0] aes_key_q;
  logic [AES_BLK_W-1:0] res_data_q;
  logic                 res_err_q;
  logic                 ov_prev_q;
  logic [CNT_W-1:0]     blk_cnt_q;

  logic accept;
  logic capture;
  logic abort;
  logic handshake;
  logic ov_edge;
  logic tmo_hit;

  // Only a fresh rising edge completes an op; a level held over from a prior op is ignored.
  assign ov_edge = bus.aes_out_valid & ~ov_prev_q;

`ifdef AES_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q == START) begin
      tmo_q <= '0;
    end else if (state_q == WAIT) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == WAIT) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && key_valid_q) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // Edge takes priority over a coincident terminal count.
        if (ov_edge) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      aes_state_q <= '0;
      aes_key_q   <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      ov_prev_q   <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      ov_prev_q <= bus.aes_out_valid;
      if ((state_q == IDLE) && key_load) begin
        key_q       <= in_key;
        key_valid_q <= 1'b1;
      end
      // Snapshot the key at accept so a same-cycle key_load only affects later blocks.
      if (accept) begin
        aes_state_q <= bus.in_data;
        aes_key_q   <= key_q;
      end
      if (capture) begin
        res_data_q <= bus.aes_out;
        res_err_q  <= 1'b0;
      end else if (abort) begin
        res_data_q <= '0;
        res_err_q  <= 1'b1;
      end
      if (handshake) begin
        blk_cnt_q <= blk_cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && key_valid_q;
  assign bus.aes_start = (state_q == START);
  assign bus.aes_state = aes_state_q;
  assign bus.aes_key   = aes_key_q;
  assign bus.res_valid = (state_q == HOLD);
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign busy          = (state_q != IDLE);
  assign blk_cnt       = blk_cnt_q;

endmodule

// File: tb/tb_aes_req_ctrl.sv
// Self-checking bench for aes_req_ctrl: behavioural engine model plus result scoreboard.
module tb_aes_req_ctrl;
  import aes_pkg::*;

  localparam int unsigned TMO = 64;
  localparam int unsigned CW  = 4;
  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_B =
    256'hdeadbeef_0badf00d_12345678_9abcdef0_cafebabe_55aa55aa_0f0f0f0f_f0f0f0f0;

  logic           clk = 1'b0;
  logic           rst;
  logic           key_load;
  logic [255:0]   in_key;
  logic           busy;
  logic [CW-1:0]  blk_cnt;

  aes_req_ctrl_if bus ();

  aes_req_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_load(key_load),
    .in_key  (in_key),
    .bus     (bus.master),
    .busy    (busy),
    .blk_cnt (blk_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         err;
  } res_t;

  res_t          sb_q[$];
  int            total = 0;
  int            bad = 0;
  logic [255:0]  model_key;
  logic [CW-1:0] exp_cnt;
  int            eng_lat = 1;
  bit            eng_sticky = 1'b0;
  bit            eng_mute = 1'b0;
  int            eng_starts = 0;

  // Stand-in cipher: the FIPS vector is exact, anything else is a key-dependent mix.
  function automatic logic [127:0] eng_f(input logic [127:0] s, input logic [255:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return s ^ k[127:0] ^ {k[191:128], k[255:192]};
  endfunction

  initial begin : engine
    logic [127:0] s;
    logic [255:0] k;
    bus.aes_out       = '0;
    bus.aes_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.aes_start) begin
        eng_starts++;
        if (!eng_mute) begin
          s = bus.aes_state;
          k = bus.aes_key;
          repeat (eng_lat) @(negedge clk);
          if (bus.aes_out_valid) begin
            bus.aes_out_valid = 1'b0;
            @(negedge clk);
          end
          bus.aes_out       = eng_f(s, k);
          bus.aes_out_valid = 1'b1;
          if (!eng_sticky) begin
            @(negedge clk);
            bus.aes_out_valid = 1'b0;
          end
        end
      end
    end
  end

  // Offers one block; returns at the negedge of the START cycle when accepted.
  task automatic send(input logic [127:0] d, input bit to_err, output bit acc);
    res_t r;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int n = 0; n < 100 && !acc; n++) begin
      if (bus.in_ready) acc = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (acc) begin
      r.data = to_err ? 128'h0 : eng_f(d, model_key);
      r.err  = to_err;
      sb_q.push_back(r);
    end
  endtask

  task automatic wait_res(input int limit, output int cyc, output bit ok);
    cyc = 0;
    while (!bus.res_valid && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    ok = bus.res_valid;
  endtask

  task automatic take(output logic [127:0] d, output logic e, output res_t exp, output bit have);
    d = bus.res_data;
    e = bus.res_err;
    have = (sb_q.size() != 0);
    if (have) exp = sb_q.pop_front();
    else begin
      exp.data = 'x;
      exp.err  = 1'bx;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0 || bus.aes_start !== 1'b0 || bus.res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy=%b start=%b rv=%b busy=%b want all 0",
               bus.in_ready, bus.aes_start, bus.res_valid, busy);
    end
    total++;
    if (blk_cnt !== '0) begin
      bad++;
      $display("FAIL reset_cnt: got %h want 0", blk_cnt);
    end
    total++;
    if (bus.aes_key !== '0 || bus.aes_state !== '0 || bus.res_data !== '0 || bus.res_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: got state=%h res=%h err=%b want 0",
               bus.aes_state, bus.res_data, bus.res_err);
    end
    rst = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
  endtask

  task automatic test_gated;
    int seen = 0;
    int s0 = eng_starts;
    bus.in_valid = 1'b1;
    bus.in_data  = FIPS_PT;
    repeat (10) begin
      if (bus.in_ready !== 1'b0) seen++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL gated_ready: got %0d cycles ready want 0", seen);
    end
    total++;
    if (eng_starts != s0) begin
      bad++;
      $display("FAIL gated_start: got %0d starts want 0", eng_starts - s0);
    end
  endtask

  task automatic test_fips;
    bit acc, ok, have;
    int cyc;
    int s0;
    logic [127:0] d;
    logic e;
    res_t exp;
    key_load = 1'b1;
    in_key   = FIPS_KEY;
    @(negedge clk);
    key_load  = 1'b0;
    model_key = FIPS_KEY;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL key_ready: got %b want 1", bus.in_ready);
    end
    eng_lat = 1;
    s0 = eng_starts;
    send(FIPS_PT, 1'b0, acc);
    total++;
    if (!acc || bus.aes_start !== 1'b1 || bus.aes_state !== FIPS_PT || bus.aes_key !== FIPS_KEY) begin
      bad++;
      $display("FAIL fips_start: got acc=%b start=%b state=%h want 1 1 %h",
               acc, bus.aes_start, bus.aes_state, FIPS_PT);
    end
    wait_res(20, cyc, ok);
    total++;
    if (!ok || cyc + 1 != eng_lat + 2) begin
      bad++;
      $display("FAIL fips_latency: got ok=%b lat=%0d want %0d", ok, cyc + 1, eng_lat + 2);
    end
    take(d, e, exp, have);
    total++;
    if (!have || d !== exp.data || e !== exp.err || d !== FIPS_CT) begin
      bad++;
      $display("FAIL fips_data: got %h err=%b want %h err=0", d, e, FIPS_CT);
    end
    total++;
    if (eng_starts - s0 != 1 || blk_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL fips_count: got starts=%0d cnt=%h want 1 %h", eng_starts - s0, blk_cnt, exp_cnt);
    end
  endtask

  task automatic test_key_change;
    bit acc, ok, have;
    int cyc;
    logic [127:0] d;
    logic e;
    res_t exp, r;
    eng_lat = 10;
    send(128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978, 1'b0, acc);
    @(negedge clk);
    key_load = 1'b1;
    in_key   = KEY_B;
    @(negedge clk);
    key_load = 1'b0;
    wait_res(40, cyc, ok);
    take(d, e, exp, have);
    total++;
    if (!acc || !ok || !have || d !== exp.data || e !== exp.err) begin
      bad++;
      $display("FAIL key_wait_a: got %h want %h", d, exp.data);
    end
    send(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, acc);
    wait_res(40, cyc, ok);
    take(d, e, exp, have);
    total++;
    if (!acc || !ok || !have || d !== exp.data || e !== exp.err) begin
      bad++;
      $display("FAIL key_wait_b: got %h want %h", d, exp.data);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL key_same_ready: got %b want 1", bus.in_ready);
    end
    key_load     = 1'b1;
    in_key       = KEY_B;
    bus.in_valid = 1'b1;
    bus.in_data  = 128'hfeed_face_0000_1111_2222_3333_4444_5555;
    @(negedge clk);
    key_load     = 1'b0;
    bus.in_valid = 1'b0;
    r.data = eng_f(128'hfeed_face_0000_1111_2222_3333_4444_5555, model_key);
    r.err  = 1'b0;
    sb_q.push_back(r);
    model_key = KEY_B;
    wait_res(40, cyc, ok);
    take(d, e, exp, have);
    total++;
    if (!ok || !have || d !== exp.data || e !== exp.err) begin
      bad++;
      $display("FAIL key_same_cycle: got %h want %h", d, exp.data);
    end
    send(128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000, 1'b0, acc);
    wait_res(40, cyc, ok);
    take(d, e, exp, have);
    total++;
    if (!acc || !ok || !have || d !== exp.data || e !== exp.err) begin
      bad++;
      $display("FAIL key_new: got %h want %h", d, exp.data);
    end
  endtask

  task automatic test_backpressure;
    bit acc, ok, have;
    int cyc;
    int viol = 0;
    logic [127:0] d, d0;
    logic e;
    res_t exp;
    eng_lat = 3;
    send(128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_1234_4321, 1'b0, acc);
    wait_res(40, cyc, ok);
    d0 = bus.res_data;
    repeat (20) begin
      if (bus.res_valid !== 1'b1 || bus.res_data !== d0 || bus.in_ready !== 1'b0) viol++;
      @(negedge clk);
    end
    total++;
    if (!acc || !ok || viol != 0) begin
      bad++;
      $display("FAIL bp_hold: got %0d bad cycles ok=%b want 0 ok=1", viol, ok);
    end
    take(d, e, exp, have);
    total++;
    if (!have || d !== exp.data || e !== exp.err) begin
      bad++;
      $display("FAIL bp_data: got %h want %h", d, exp.data);
    end
    total++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0 || blk_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL bp_release: got busy=%b rdy=%b rv=%b cnt=%h want 0 1 0 %h",
               busy, bus.in_ready, bus.res_valid, blk_cnt, exp_cnt);
    end
  endtask

  task automatic test_stale;
    bit acc, ok, have;
    int cyc;
    logic [127:0] d;
    logic e;
    res_t exp;
    eng_sticky = 1'b1;
    eng_lat    = 2;
    send(128'h0000_0000_0000_0000_0000_0000_0000_00a1, 1'b0, acc);
    wait_res(40, cyc, ok);
    take(d, e, exp, have);
    total++;
    if (!acc || !ok || !have || d !== exp.data) begin
      bad++;
      $display("FAIL stale_first: got %h want %h", d, exp.data);
    end
    eng_lat = 4;
    send(128'h0000_0000_0000_0000_0000_0000_0000_00b2, 1'b0, acc);
    wait_res(40, cyc, ok);
    take(d, e, exp, have);
    total++;
    if (!acc || !ok || !have || d !== exp.data || e !== exp.err) begin
      bad++;
      $display("FAIL stale_second: got %h want %h", d, exp.data);
    end
    eng_sticky        = 1'b0;
    bus.aes_out_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    bit acc, ok, have;
    int cyc;
    logic [127:0] d;
    logic e;
    res_t exp;
`ifdef AES_TIMEOUT_EN
    eng_mute = 1'b1;
    send(128'h7777_0000_7777_0000_7777_0000_7777_0000, 1'b1, acc);
    wait_res(200, cyc, ok);
    eng_mute = 1'b0;
    total++;
    if (!acc || !ok || cyc != TMO + 1) begin
      bad++;
      $display("FAIL tmo_abort_time: got ok=%b cyc=%0d want 1 %0d", ok, cyc, TMO + 1);
    end
    take(d, e, exp, have);
    total++;
    if (!have || d !== 128'h0 || e !== 1'b1 || d !== exp.data || e !== exp.err) begin
      bad++;
      $display("FAIL tmo_abort_data: got %h err=%b want 0 err=1", d, e);
    end
    eng_lat = TMO;
    send(128'h8888_1111_8888_1111_8888_1111_8888_1111, 1'b0, acc);
    wait_res(200, cyc, ok);
    take(d, e, exp, have);
    total++;
    if (!acc || !ok || cyc != TMO + 1 || !have || d !== exp.data || e !== 1'b0) begin
      bad++;
      $display("FAIL tmo_edge_wins: got cyc=%0d %h err=%b want %0d %h err=0",
               cyc, d, e, TMO + 1, exp.data);
    end
`else
    eng_mute = 1'b1;
    send(128'h7777_0000_7777_0000_7777_0000_7777_0000, 1'b0, acc);
    wait_res(TMO + 40, cyc, ok);
    total++;
    if (!acc || ok || busy !== 1'b1 || bus.res_err !== 1'b0) begin
      bad++;
      $display("FAIL wait_unbounded: got rv=%b busy=%b err=%b want 0 1 0", ok, busy, bus.res_err);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    eng_mute = 1'b0;
    exp_cnt  = '0;
    key_load = 1'b1;
    in_key   = model_key;
    @(negedge clk);
    key_load = 1'b0;
    d   = '0;
    e   = 1'b0;
    exp.data = '0;
    exp.err  = 1'b0;
    have = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_wait;
    bit acc;
    eng_lat = 20;
    send(128'h4242_4242_4242_4242_4242_4242_4242_4242, 1'b0, acc);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (!acc || busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 || blk_cnt !== '0) begin
      bad++;
      $display("FAIL rst_async: got busy=%b rdy=%b rv=%b cnt=%h want 0 0 0 0",
               busy, bus.in_ready, bus.res_valid, blk_cnt);
    end
    @(negedge clk);
    rst     = 1'b0;
    exp_cnt = '0;
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    repeat (25) @(negedge clk);
    total++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_discard: got rv=%b rdy=%b want 0 0", bus.res_valid, bus.in_ready);
    end
    key_load  = 1'b1;
    in_key    = KEY_B;
    @(negedge clk);
    key_load  = 1'b0;
    model_key = KEY_B;
  endtask

  task automatic test_back_to_back;
    bit acc, ok, have;
    int cyc;
    logic [127:0] d;
    logic e;
    res_t exp;
    eng_lat = 1;
    for (int i = 0; i < 16; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, 1'b0, acc);
      wait_res(20, cyc, ok);
      take(d, e, exp, have);
      total++;
      if (!acc || !ok || !have || d !== exp.data || e !== exp.err) begin
        bad++;
        $display("FAIL b2b_data[%0d]: got %h want %h", i, d, exp.data);
      end
      total++;
      if (blk_cnt !== exp_cnt || bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_cnt[%0d]: got cnt=%h rdy=%b want %h 1", i, blk_cnt, bus.in_ready, exp_cnt);
      end
    end
    total++;
    if (blk_cnt !== 4'h0) begin
      bad++;
      $display("FAIL cnt_wrap: got %h want 0", blk_cnt);
    end
  endtask

  initial begin
    rst           = 1'b1;
    key_load      = 1'b0;
    in_key        = '0;
    model_key     = '0;
    exp_cnt       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_gated();
    test_fips();
    test_key_change();
    test_backpressure();
    test_stale();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
